// File: rtl/ext_alu_fu.sv
// External ALU functional unit: multi-cycle ADD..SRL/MUL (optional DIV) behind the DE<->FU strobe bus.
// Define FU_DIV_EN to make opcode 8 an unsigned restoring divide; otherwise opcode 8 is rejected.
module ext_alu_fu #(
    parameter int DBITS   = 32,
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [70:0] from_DE_to_FU,
    output logic [34:0] from_FU_to_DE,
    output logic [1:0]  fu_state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = 16;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_MUL = 4'd7,
                           OP_DIV = 4'd8;

    logic             wr_aluop, wr_op1, wr_op2, rd_op3;
    logic [DBITS-1:0] wdata;
    logic [3:0]       opcode;
    logic             opcode_ok;
    logic             unused_bus;

    assign wr_aluop   = from_DE_to_FU[0];
    assign wr_op1     = from_DE_to_FU[1];
    assign wr_op2     = from_DE_to_FU[2];
    assign wdata      = from_DE_to_FU[34:3];
    assign rd_op3     = from_DE_to_FU[35];
    assign unused_bus = ^from_DE_to_FU[70:36];
    assign opcode     = wdata[3:0];
`ifdef FU_DIV_EN
    assign opcode_ok  = (opcode <= OP_DIV);
`else
    assign opcode_ok  = (opcode <= OP_MUL);
`endif

    state_t           state_q, state_d;
    logic [DBITS-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [DBITS-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]       aluop_q, aluop_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [30:0]      op3_q, op3_d;
    logic             err_q, err_d, ovf_q, ovf_d, done_q, done_d;

    logic [DBITS-1:0] alu_res, mul_acc_next, result;

    always_comb begin
        alu_res = '0;
        case (aluop_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLL:  alu_res = a_q << b_q[4:0];
            OP_SRL:  alu_res = a_q >> b_q[4:0];
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiply: a shifts left, b shifts right, one partial product per cycle.
    assign mul_acc_next = acc_q + (b_q[0] ? a_q : '0);

`ifdef FU_DIV_EN
    // Restoring divide: a holds the dividend shifting out and the quotient shifting in.
    logic [DBITS-1:0] rem_q, rem_d, rem_next, quo_next;
    logic [DBITS:0]   rem_sh, rem_sub;
    logic             div_ge;

    assign rem_sh   = {rem_q, a_q[DBITS-1]};
    assign div_ge   = (rem_sh >= {1'b0, b_q});
    assign rem_sub  = rem_sh - {1'b0, b_q};
    assign rem_next = div_ge ? rem_sub[DBITS-1:0] : rem_sh[DBITS-1:0];
    assign quo_next = {a_q[DBITS-2:0], div_ge};
`endif

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        aluop_d = aluop_q;
        cnt_d   = cnt_q;
        op3_d   = op3_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        result  = alu_res;
`ifdef FU_DIV_EN
        rem_d   = rem_q;
`endif
        if (rd_op3) begin
            done_d = 1'b0;
        end
        if (state_q == S_BUSY) begin
            if (wr_aluop || wr_op1 || wr_op2) begin
                err_d = 1'b1;
            end
            if (aluop_q == OP_MUL) begin
                acc_d  = mul_acc_next;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                result = mul_acc_next;
            end
`ifdef FU_DIV_EN
            if (aluop_q == OP_DIV) begin
                rem_d  = rem_next;
                a_d    = quo_next;
                result = quo_next;
            end
`endif
            if (cnt_q == '0) begin
                op3_d   = result[30:0];
                ovf_d   = result[DBITS-1] ^ result[DBITS-2];
                done_d  = 1'b1;
                state_d = S_DONE;
`ifdef FU_DIV_EN
                if (aluop_q == OP_DIV && b_q == '0) begin
                    err_d = 1'b1;
                    ovf_d = 1'b1;
                end
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            if (wr_op1) op1_d = wdata;
            if (wr_op2) op2_d = wdata;
            if (wr_aluop) begin
                if (opcode_ok) begin
                    aluop_d = opcode;
                    a_d     = op1_d;
                    b_d     = op2_d;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = S_BUSY;
                    cnt_d   = (opcode >= OP_MUL) ? CW'(DBITS - 1) : CW'(ALU_LAT - 1);
`ifdef FU_DIV_EN
                    rem_d   = '0;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            aluop_q <= '0;
            cnt_q   <= '0;
            op3_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef FU_DIV_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            aluop_q <= aluop_d;
            cnt_q   <= cnt_d;
            op3_q   <= op3_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef FU_DIV_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign from_FU_to_DE = {(state_q == S_BUSY), err_q, ovf_q, done_q, op3_q};
    assign fu_state_dbg  = state_q;

endmodule

// File: tb/tb_ext_alu_fu.sv
// Directed bench for ext_alu_fu: hand-computed vectors for ALU ops, MUL, strobe drops, reset abort and opcode 8.
module tb_ext_alu_fu;

    logic        clk = 1'b0;
    logic        reset;
    logic [70:0] bus;
    logic [34:0] fu_out;
    logic [1:0]  st;

    int total = 0;
    int bad   = 0;

    ext_alu_fu dut (
        .clk           (clk),
        .reset         (reset),
        .from_DE_to_FU (bus),
        .from_FU_to_DE (fu_out),
        .fu_state_dbg  (st)
    );

    always #5 clk = ~clk;

    wire [30:0] op3  = fu_out[30:0];
    wire [2:0]  csr  = fu_out[33:31];
    wire        busy = fu_out[34];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; ignored upper bits carry junk to prove they are ignored.
    task automatic strobe(input logic [2:0] wr, input logic rd, input logic [31:0] d);
        bus        = '0;
        bus[70:36] = '1;
        bus[2:0]   = wr;
        bus[34:3]  = d;
        bus[35]    = rd;
        tick();
        bus = '0;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        strobe(3'b010, 1'b0, a);
        strobe(3'b100, 1'b0, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int n;

    initial begin
        bus   = '0;
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op3", 32'(op3), 32'd0);
        check("rst_csr", 32'(csr), 32'd0);
        check("rst_state", 32'(st), 32'd0);

        set_ops(32'd5, 32'd7);
        strobe(3'b001, 1'b0, 32'd0);
        check("add_busy", 32'(busy), 32'd1);
        check("add_state", 32'(st), 32'd1);
        wait_idle(n);
        check("add_lat", 32'(n), 32'd2);
        check("add_op3", 32'(op3), 32'd12);
        check("add_csr", 32'(csr), 32'b001);
        check("add_state_done", 32'(st), 32'd2);

        set_ops(32'h4000_0000, 32'h4000_0000);
        strobe(3'b001, 1'b0, 32'd0);
        wait_idle(n);
        check("addv_op3", 32'(op3), 32'd0);
        check("addv_csr", 32'(csr), 32'b011);

        set_ops(32'd3, 32'd5);
        strobe(3'b001, 1'b0, 32'd1);
        wait_idle(n);
        check("sub_op3", 32'(op3), 32'h7FFF_FFFE);
        check("sub_csr", 32'(csr), 32'b001);

        set_ops(32'd1, 32'h21);
        strobe(3'b001, 1'b0, 32'd5);
        wait_idle(n);
        check("sll_op3", 32'(op3), 32'd2);

        set_ops(32'h8000_0000, 32'd31);
        strobe(3'b001, 1'b0, 32'd6);
        wait_idle(n);
        check("srl_op3", 32'(op3), 32'd1);

        set_ops(32'hF0F0_1234, 32'h0FF0_FF00);
        strobe(3'b001, 1'b0, 32'd4);
        wait_idle(n);
        check("xor_op3", 32'(op3), 32'h7F00_ED34);

        set_ops(32'hFFFF_FFFD, 32'd6);
        strobe(3'b001, 1'b0, 32'd7);
        wait_idle(n);
        check("mul_lat", 32'(n), 32'd32);
        check("mul_op3", 32'(op3), 32'h7FFF_FFEE);
        check("mul_csr", 32'(csr), 32'b001);

        strobe(3'b000, 1'b1, 32'd0);
        check("rd_csr", 32'(csr), 32'b000);
        check("rd_op3", 32'(op3), 32'h7FFF_FFEE);

        strobe(3'b001, 1'b0, 32'd9);
        check("inv_csr", 32'(csr), 32'b100);
        check("inv_state", 32'(st), 32'd2);
        check("inv_busy", 32'(busy), 32'd0);

        // Reset arriving mid-MUL aborts it.
        strobe(3'b001, 1'b0, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        do_reset();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_op3", 32'(op3), 32'd0);
        check("abort_csr", 32'(csr), 32'd0);

        set_ops(32'hFFFF_FFFD, 32'd6);
        strobe(3'b001, 1'b0, 32'd7);
        tick(); tick(); tick();
        strobe(3'b001, 1'b0, 32'd0);
        check("drop_alu_err", 32'(csr), 32'b100);
        check("drop_alu_busy", 32'(busy), 32'd1);
        strobe(3'b010, 1'b0, 32'd1);
        wait_idle(n);
        check("drop_op3", 32'(op3), 32'h7FFF_FFEE);
        check("drop_csr", 32'(csr), 32'b101);
        // op1 kept 0xFFFFFFFD, op2 kept 6: ADD gives 3 and clears err.
        strobe(3'b001, 1'b0, 32'd0);
        wait_idle(n);
        check("drop_keep_op3", 32'(op3), 32'd3);
        check("drop_keep_csr", 32'(csr), 32'b001);

        do_reset();
`ifdef FU_DIV_EN
        set_ops(32'd100, 32'd7);
        strobe(3'b001, 1'b0, 32'd8);
        wait_idle(n);
        check("div_lat", 32'(n), 32'd32);
        check("div_op3", 32'(op3), 32'd14);
        check("div_csr", 32'(csr), 32'b001);
        set_ops(32'd100, 32'd0);
        strobe(3'b001, 1'b0, 32'd8);
        wait_idle(n);
        check("div0_op3", 32'(op3), 32'h7FFF_FFFF);
        check("div0_csr", 32'(csr), 32'b111);
`else
        set_ops(32'd100, 32'd7);
        strobe(3'b001, 1'b0, 32'd8);
        check("op8_csr", 32'(csr), 32'b100);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy) n++;
            tick();
        end
        check("op8_busy_cycles", 32'(n), 32'd0);
        check("op8_state", 32'(st), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
